reg_8: RTL and testbench

8-bit general-purpose CPU register with synchronous load, increment, decrement and clear, plus zero and carry status flags. It is the storage element for the datapath's architectural registers. The register file and ALU drive `dIn` and the control strobes, and `dOut` feeds the operand buses. State changes only on the rising edge of `clk`.

---
 rtl/reg_8_if.sv | 30 +++
 rtl/reg_8.sv | 50 +++++
 tb/tb_reg_8.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_8_if.sv
// Control/data bundle for the 8-bit register. REG8_PARITY_EN adds the parity output.
interface reg_8_if;
    logic       writeEn;
    logic [7:0] dIn;
    logic       incEn;
    logic       decEn;
    logic       clrEn;
    logic [7:0] dOut;
    logic       zero;
    logic       carry;
`ifdef REG8_PARITY_EN
    logic       parity;
`endif

    modport master (
        output writeEn, dIn, incEn, decEn, clrEn,
`ifdef REG8_PARITY_EN
        input  parity,
`endif
        input  dOut, zero, carry
    );

    modport slave (
        input  writeEn, dIn, incEn, decEn, clrEn,
`ifdef REG8_PARITY_EN
        output parity,
`endif
        output dOut, zero, carry
    );
endinterface

// File: rtl/reg_8.sv
// 8-bit register with prioritized clear/load/inc/dec, zero and carry flags.
// Optional even-parity output when REG8_PARITY_EN is defined.
module reg_8 #(
    parameter logic [7:0] RESET_VALUE = 8'h00
) (
    input logic   clk,
    input logic   rst,
    reg_8_if.slave bus
);

    logic [7:0] dout_q, dout_d;
    logic       carry_q, carry_d;

    always_comb begin
        dout_d  = dout_q;
        carry_d = carry_q;
        if (bus.clrEn) begin
            dout_d  = 8'h00;
            carry_d = 1'b0;
        end else if (bus.writeEn) begin
            dout_d  = bus.dIn;
            carry_d = 1'b0;
        end else if (bus.incEn) begin
            // Ninth bit of the sum is the carry out of 8'hFF.
            {carry_d, dout_d} = {1'b0, dout_q} + 9'd1;
        end else if (bus.decEn) begin
            carry_d = (dout_q == 8'h00);
            dout_d  = dout_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= RESET_VALUE;
            carry_q <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            carry_q <= carry_d;
        end
    end

    assign bus.dOut  = dout_q;
    assign bus.carry = carry_q;
    assign bus.zero  = (dout_q == 8'h00);

`ifdef REG8_PARITY_EN
    assign bus.parity = ^dout_q;
`endif

endmodule

// File: tb/tb_reg_8.sv
// Self-checking bench for reg_8: directed plan steps then random strobes vs an integer model.
module tb_reg_8;
    logic clk = 1'b0;
    logic rst;

    reg_8_if bus ();

    reg_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state as plain integers.
    int m_val;
    int m_carry;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit w, input int d,
                              input bit i, input bit dc);
        if (r) begin
            m_val = 0; m_carry = 0;
        end else if (c) begin
            m_val = 0; m_carry = 0;
        end else if (w) begin
            m_val = d; m_carry = 0;
        end else if (i) begin
            m_carry = (m_val == 255) ? 1 : 0;
            m_val   = (m_val + 1) % 256;
        end else if (dc) begin
            m_carry = (m_val == 0) ? 1 : 0;
            m_val   = (m_val + 255) % 256;
        end
    endtask

    // Apply one edge of stimulus, then compare all outputs with the model.
    task automatic step(input string tag, input bit r, input bit c, input bit w,
                        input logic [7:0] d, input bit i, input bit dc);
        @(negedge clk);
        rst         = r;
        bus.clrEn   = c;
        bus.writeEn = w;
        bus.dIn     = d;
        bus.incEn   = i;
        bus.decEn   = dc;
        @(posedge clk);
        model_step(r, c, w, int'(d), i, dc);
        #1;
        check({tag, ".dOut"}, bus.dOut, m_val[7:0]);
        check({tag, ".carry"}, {7'd0, bus.carry}, m_carry[7:0]);
        check({tag, ".zero"}, {7'd0, bus.zero}, (m_val == 0) ? 8'd1 : 8'd0);
`ifdef REG8_PARITY_EN
        check({tag, ".parity"}, {7'd0, bus.parity}, {7'd0, ^m_val[7:0]});
`endif
    endtask

    initial begin
        rst = 1'b0;
        bus.clrEn = 1'b0; bus.writeEn = 1'b0; bus.dIn = 8'h00;
        bus.incEn = 1'b0; bus.decEn = 1'b0;
        m_val = 0; m_carry = 0;

        step("reset", 1, 0, 1, 8'hAA, 0, 0);
        check("reset.const", bus.dOut, 8'h00);

        step("load", 0, 0, 1, 8'hCC, 0, 0);
        step("hold", 0, 0, 0, 8'hFF, 0, 0);
        check("hold.const", bus.dOut, 8'hCC);

        step("inc.load", 0, 0, 1, 8'hFE, 0, 0);
        step("inc1", 0, 0, 0, 8'h00, 1, 0);
        check("inc1.const", bus.dOut, 8'hFF);
        step("inc2", 0, 0, 0, 8'h00, 1, 0);
        check("inc2.const", {7'd0, bus.carry}, 8'd1);

        step("dec.load", 0, 0, 1, 8'h01, 0, 0);
        step("dec1", 0, 0, 0, 8'h00, 0, 1);
        step("dec2", 0, 0, 0, 8'h00, 0, 1);
        check("dec2.const", bus.dOut, 8'hFF);

        step("pri.load", 0, 0, 1, 8'h55, 0, 0);
        step("pri.clr", 0, 1, 1, 8'h12, 1, 0);
        check("pri.clr.const", bus.dOut, 8'h00);
        step("pri.wr", 0, 0, 1, 8'h12, 1, 0);
        check("pri.wr.const", bus.dOut, 8'h12);
        step("pri.incdec", 0, 0, 0, 8'h00, 1, 1);
        check("pri.incdec.const", bus.dOut, 8'h13);

        step("rst.mid", 1, 0, 0, 8'h00, 1, 0);

`ifdef REG8_PARITY_EN
        step("par.07", 0, 0, 1, 8'h07, 0, 0);
        check("par.07.const", {7'd0, bus.parity}, 8'd1);
        step("par.03", 0, 0, 1, 8'h03, 0, 0);
        check("par.03.const", {7'd0, bus.parity}, 8'd0);
`endif

        for (int k = 0; k < 400; k++) begin
            step("rand",
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 8'($urandom),
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 1) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
